// File: rtl/wbus_if.sv
// Write-bus bundle between the CPU data-memory write port, the posted-write
// bridge and one peripheral slave.
interface wbus_if #(
  parameter int SLAVEADDR_WIDTH = 24
);
  logic                       dmem_wr;
  logic [31:0]                dmem_waddr;
  logic [31:0]                dmem_wdata;
  logic [3:0]                 dmem_wstrb;
  logic                       dmem_wstall;
  logic                       slave_wr;
  logic [SLAVEADDR_WIDTH-1:0] slave_waddr;
  logic [31:0]                slave_wdata;
  logic [3:0]                 slave_wstrb;
  logic                       slave_wready;

  // Environment side: CPU write requests plus the peripheral's ready.
  modport master (
    output dmem_wr, dmem_waddr, dmem_wdata, dmem_wstrb, slave_wready,
    input  dmem_wstall, slave_wr, slave_waddr, slave_wdata, slave_wstrb
  );

  // Bridge side.
  modport slave (
    input  dmem_wr, dmem_waddr, dmem_wdata, dmem_wstrb, slave_wready,
    output dmem_wstall, slave_wr, slave_waddr, slave_wdata, slave_wstrb
  );
endinterface

// File: rtl/wbus_bridge.sv
// Posted-write bridge: decodes CPU writes against a base window and queues them
// in a small FIFO drained to one slave. Define WBUS_STRB_EN to carry byte strobes.
module wbus_bridge #(
  parameter logic [31:0] BASEADDR        = 32'h0000_0000,
  parameter int          BASEADDR_WIDTH  = 8,
  parameter int          SLAVEADDR_WIDTH = 32 - BASEADDR_WIDTH,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  wbus_if.slave                       bus,
  output logic                        wbus_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [31:0]       MASK     = ~(32'hFFFF_FFFF >> BASEADDR_WIDTH);
  localparam logic [CNT_W-1:0]  FULL_LVL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  logic [SLAVEADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [31:0]                data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;

  logic sel;
  logic full;
  logic push;
  logic pop;

  // Stall depends only on the registered fill state so the CPU never sees a
  // combinational path from the slave's ready.
  always_comb begin
    sel             = ((bus.dmem_waddr & MASK) == BASEADDR);
    full            = (count == FULL_LVL);
    push            = bus.dmem_wr & sel & ~full;
    pop             = bus.slave_wr & bus.slave_wready;
    bus.dmem_wstall = bus.dmem_wr & sel & full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      addr_mem[wr_ptr] <= bus.dmem_waddr[SLAVEADDR_WIDTH-1:0];
      data_mem[wr_ptr] <= bus.dmem_wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef WBUS_STRB_EN
  logic [3:0] strb_mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) strb_mem[i] <= '0;
    end else if (push) begin
      strb_mem[wr_ptr] <= bus.dmem_wstrb;
    end
  end

  assign bus.slave_wstrb = strb_mem[rd_ptr];
`else
  logic unused_strb;

  assign unused_strb     = ^bus.dmem_wstrb;
  assign bus.slave_wstrb = 4'hF;
`endif

  assign bus.slave_wr    = (count != '0);
  assign bus.slave_waddr = addr_mem[rd_ptr];
  assign bus.slave_wdata = data_mem[rd_ptr];
  assign wbus_busy       = (count != '0);
  assign fifo_level      = count;

endmodule

// File: tb/tb_wbus_bridge.sv
// Directed bench for wbus_bridge: a per-cycle vector table plus hand sequences
// for pointer wrap, strobe forwarding and reset mid-drain.
module tb_wbus_bridge;

  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef WBUS_STRB_EN
  localparam logic [3:0] EXP_STRB  = 4'b0101;
  localparam logic [3:0] RST_STRB  = 4'h0;
`else
  localparam logic [3:0] EXP_STRB  = 4'hF;
  localparam logic [3:0] RST_STRB  = 4'hF;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wbus_busy;
  logic [2:0] fifo_level;

  int total = 0;
  int bad = 0;

  wbus_if #(.SLAVEADDR_WIDTH(24)) bus ();

  wbus_bridge #(
    .BASEADDR(BASE),
    .BASEADDR_WIDTH(8),
    .SLAVEADDR_WIDTH(24),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .wbus_busy(wbus_busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wready;
    logic        e_stall;
    logic        e_swr;
    logic [2:0]  e_level;
    logic [23:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vq[$];

  task automatic addVec(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic wready, input logic e_stall, input logic e_swr,
                        input logic [2:0] e_level, input logic [23:0] e_addr,
                        input logic [31:0] e_data);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.wready = wready;
    v.e_stall = e_stall; v.e_swr = e_swr; v.e_level = e_level;
    v.e_addr = e_addr; v.e_data = e_data;
    vq.push_back(v);
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic wready);
    bus.dmem_wr      = wr;
    bus.dmem_waddr   = addr;
    bus.dmem_wdata   = data;
    bus.dmem_wstrb   = strb;
    bus.slave_wready = wready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    int          sent;
    int          delivered;
    int          cyc;
    int          cnt;
    int          idx;
    logic        wr;
    logic        rdy;
    logic        push;
    logic        pop;

    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

    // Decode, then fill to full with the slave stalled, then push+pop at full.
    addVec(1, BASE | 32'h10,  32'hDEAD_BEEF, 1, 0, 0, 0, 24'h0,   32'h0);
    addVec(0, 32'h0,          32'h0,         1, 0, 1, 1, 24'h10,  32'hDEAD_BEEF);
    addVec(1, 32'h4100_0010,  32'h1111,      1, 0, 0, 0, 24'h0,   32'h0);
    addVec(0, 32'h0,          32'h0,         1, 0, 0, 0, 24'h0,   32'h0);
    addVec(1, BASE | 32'h104, 32'd1,         0, 0, 0, 0, 24'h0,   32'h0);
    addVec(1, BASE | 32'h108, 32'd2,         0, 0, 1, 1, 24'h104, 32'd1);
    addVec(1, BASE | 32'h10C, 32'd3,         0, 0, 1, 2, 24'h104, 32'd1);
    addVec(1, BASE | 32'h110, 32'd4,         0, 0, 1, 3, 24'h104, 32'd1);
    addVec(1, BASE | 32'h114, 32'd5,         0, 1, 1, 4, 24'h104, 32'd1);
    addVec(1, BASE | 32'h114, 32'd5,         0, 1, 1, 4, 24'h104, 32'd1);
    addVec(1, BASE | 32'h114, 32'd5,         1, 1, 1, 4, 24'h104, 32'd1);
    addVec(1, BASE | 32'h114, 32'd5,         1, 0, 1, 3, 24'h108, 32'd2);
    addVec(0, 32'h0,          32'h0,         1, 0, 1, 3, 24'h10C, 32'd3);
    addVec(0, 32'h0,          32'h0,         1, 0, 1, 2, 24'h110, 32'd4);
    addVec(0, 32'h0,          32'h0,         1, 0, 1, 1, 24'h114, 32'd5);
    addVec(0, 32'h0,          32'h0,         1, 0, 0, 0, 24'h0,   32'h0);
    // Back-to-back writes with the slave always ready stay at level 1.
    addVec(1, BASE | 32'h200, 32'hA0,        1, 0, 0, 0, 24'h0,   32'h0);
    addVec(1, BASE | 32'h204, 32'hA1,        1, 0, 1, 1, 24'h200, 32'hA0);
    addVec(0, 32'h0,          32'h0,         1, 0, 1, 1, 24'h204, 32'hA1);
    addVec(0, 32'h0,          32'h0,         1, 0, 0, 0, 24'h0,   32'h0);

    #2;
    checkOutput("rst_slave_wr", bus.slave_wr, 0);
    checkOutput("rst_busy", wbus_busy, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_stall", bus.dmem_wstall, 0);
    checkOutput("rst_waddr", bus.slave_waddr, 0);
    checkOutput("rst_wdata", bus.slave_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    foreach (vq[i]) begin
      applyStimulus(vq[i].wr, vq[i].addr, vq[i].data, 4'hF, vq[i].wready);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_stall", i), bus.dmem_wstall, vq[i].e_stall);
      checkOutput($sformatf("vec%0d_slave_wr", i), bus.slave_wr, vq[i].e_swr);
      checkOutput($sformatf("vec%0d_level", i), fifo_level, vq[i].e_level);
      checkOutput($sformatf("vec%0d_busy", i), wbus_busy, vq[i].e_level != 0);
      if (vq[i].e_swr) begin
        checkOutput($sformatf("vec%0d_waddr", i), bus.slave_waddr, vq[i].e_addr);
        checkOutput($sformatf("vec%0d_wdata", i), bus.slave_wdata, vq[i].e_data);
      end
      nextCycle();
    end

    // Wrap: ten writes against a toggling ready, tracked by a queue model.
    sent = 0; delivered = 0; cyc = 0; cnt = 0; rdy = 1'b0;
    while ((sent < 10 || cnt != 0) && cyc < 80) begin
      wr = (sent < 10);
      applyStimulus(wr, BASE | (32'h300 + 32'(sent) * 4), 32'(sent), 4'hF, rdy);
      @(negedge clk);
      checkOutput("wrap_level", fifo_level, cnt);
      checkOutput("wrap_stall", bus.dmem_wstall, wr && cnt == 4);
      checkOutput("wrap_slave_wr", bus.slave_wr, cnt != 0);
      if (cnt != 0) begin
        idx = int'(q[0]);
        checkOutput("wrap_wdata", bus.slave_wdata, q[0]);
        checkOutput("wrap_waddr", bus.slave_waddr, 32'h300 + 32'(idx) * 4);
      end
      pop  = (cnt != 0) && rdy;
      push = wr && (cnt < 4);
      if (pop) begin
        void'(q.pop_front());
        delivered++;
      end
      if (push) begin
        q.push_back(32'(sent));
        sent++;
      end
      cnt = q.size();
      nextCycle();
      rdy = ~rdy;
      cyc++;
    end
    checkOutput("wrap_delivered", delivered, 10);

    // Strobe forwarding.
    applyStimulus(1'b1, BASE | 32'h400, 32'h55, 4'b0101, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("strb_slave_wr", bus.slave_wr, 1);
    checkOutput("strb_value", bus.slave_wstrb, EXP_STRB);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("strb_drained", fifo_level, 0);
    nextCycle();

    // Reset mid-drain at level 3.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, BASE | (32'h500 + 32'(k) * 4), 32'h70 + 32'(k), 4'hF, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b1, BASE | 32'h600, 32'h99, 4'hF, 1'b1);
    @(negedge clk);
    checkOutput("pre_rst_level", fifo_level, 3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_slave_wr", bus.slave_wr, 0);
    checkOutput("midrst_busy", wbus_busy, 0);
    checkOutput("midrst_level", fifo_level, 0);
    checkOutput("midrst_stall", bus.dmem_wstall, 0);
    checkOutput("midrst_waddr", bus.slave_waddr, 0);
    checkOutput("midrst_wdata", bus.slave_wdata, 0);
    checkOutput("midrst_wstrb", bus.slave_wstrb, RST_STRB);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("postrst_slave_wr", bus.slave_wr, 0);
      checkOutput("postrst_level", fifo_level, 0);
    end
    nextCycle();
    applyStimulus(1'b1, BASE | 32'h700, 32'hCAFE_F00D, 4'hF, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("postrst_new_wr", bus.slave_wr, 1);
    checkOutput("postrst_new_data", bus.slave_wdata, 32'hCAFE_F00D);
    checkOutput("postrst_new_addr", bus.slave_waddr, 32'h700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
